audio_dac_tx: RTL
=================

# audio_dac_tx

Parametrised stereo audio serializer for a codec in master mode (WM8731-class). Accepts stereo sample pairs over a valid/ready interface, buffers them in a small FIFO, and shifts them out on DACDAT in left-justified, I2S or right-justified format. Timing comes from codec-driven BCLK/DACLRC, both asynchronous to the system clock. Sits between the audio sample source and the codec pins, next to the I2C register-config block.

## Interface
Parameters:
- SAMPLE_W, 16: bits per channel sample, 8..32.
- SLOT_W, 32: BCLK cycles per half-frame, used for right-justified alignment; must be ≥ SAMPLE_W.
- FIFO_DEPTH, 8: stereo frames buffered; power of two, ≥ 2.

Ports (LW = clog2(FIFO_DEPTH)+1):
- clk50M  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  format: 00 left-justified, 01 I2S, 10 right-justified, 11 treated as 00.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  FIFO can accept a pair.
- s_left  in  SAMPLE_W  left sample, two's complement.
- s_right  in  SAMPLE_W  right sample.
- bclk  in  1  codec bit clock, asynchronous.
- daclrc  in  1  codec LR clock, asynchronous.
- dacdat  out  1  serial data to codec.
- underrun  out  1  one-cycle pulse per frame sent without data.
- underrun_cnt  out  16  saturating underrun count.
- fifo_level  out  LW  frames currently stored.

## Operation
- bclk and daclrc each pass through a 2-flop synchronizer.
- A BCLK falling edge is detected on the synchronized bclk (registered 1 → current 0).
- All serializer activity advances only on detected falling edges. The codec samples dacdat on rising edges.
- The LRC level is sampled at each falling edge.
  - Left channel is lrc=1 in LJ/RJ and lrc=0 in I2S.
  - A change from the previously sampled level starts a new half-frame.
- The serializer state machine has three states:
  - IDLE: dacdat=0. Moves to LEFT at the first left half-frame start after reset.
  - LEFT: moves to RIGHT on the next half-frame start.
  - RIGHT: moves to LEFT on the next half-frame start.
- mode is latched at each left half-frame start. Changes mid-frame take effect at the next frame.
- At each left half-frame start, pop one FIFO entry into the left/right holding registers.
  - If the FIFO is empty, load zeros into both holding registers.
  - Also pulse underrun and increment underrun_cnt, which saturates at 16'hFFFF.
- The bit counter k counts falling edges since the half-frame start (k=0 at the start edge). It saturates at 63.
- dacdat for sample word D with bit index MSB = SAMPLE_W-1:
  - LJ: D[MSB-k] for k < SAMPLE_W, else 0.
  - I2S: 0 at k=0, D[MSB-(k-1)] for 1 ≤ k ≤ SAMPLE_W, else 0.
  - RJ: D[MSB-(k-(SLOT_W-SAMPLE_W))] for SLOT_W-SAMPLE_W ≤ k < SLOT_W, else 0.
- A half-frame shorter than the format needs is truncated; the new half-frame starts cleanly at k=0.
- FIFO:
  - Push on s_valid & s_ready; s_ready = !full.
  - No push-to-pop bypass: a pop attempted on an empty FIFO underruns even if a push happens in the same cycle.
  - When pop and push occur in the same cycle on a non-empty FIFO, fifo_level is unchanged.
- Reset behaviour:
  - Reset flushes the FIFO and returns the state machine to IDLE.
  - Reset mid-frame abandons the current word; output restarts at the next left half-frame start.

## Timing
- Reset values:
  - dacdat=0, s_ready=0, underrun=0, underrun_cnt=0, fifo_level=0.
  - s_ready rises the first cycle after rst deasserts.
- dacdat updates exactly 1 clk50M cycle after the cycle in which the falling edge is detected.
- Pin-to-dacdat latency is 3–4 cycles, i.e. 60–80 ns.
- BCLK high and low times must each be ≥ 4 clk50M cycles (BCLK ≤ 6.25 MHz); 3.072 MHz is supported.
- Pop and underrun occur in the same cycle as left-start detection. fifo_level reflects the pop 1 cycle later.
- s_ready deasserts in the cycle after the push that fills the FIFO.

## Structure
- Shared package audio_pkg holds:
  - mode encodings: MODE_LJ, MODE_I2S, MODE_RJ;
  - the state enum: IDLE, LEFT, RIGHT.
- Sub-module sample_fifo: a synchronous FIFO of width 2*SAMPLE_W and depth FIFO_DEPTH, with a level output.
- The synchronizers, edge detect, state machine and shift logic stay in audio_dac_tx.

## Test plan
- Reset then LJ, SAMPLE_W=16, BCLK 64 per frame. Push L=16'hA55A, R=16'h0F0F. Required:
  - left slot bits 0–15 = A55A MSB first, bits 16–31 = 0;
  - right slot = 0F0F;
  - fifo_level returns to 0.
- I2S with the same data. Required:
  - dacdat=0 at k=0 of each slot;
  - A55A at k=1..16;
  - left taken while lrc=0.
- RJ, SLOT_W=32, L=16'h8001. Required: k=0..15 are 0, k=16 is 1, k=31 is 1, k=17..30 are 0.
- Empty FIFO for 3 frames. Required:
  - dacdat constantly 0;
  - 3 underrun pulses, underrun_cnt=3.
- Push 9 pairs with FIFO_DEPTH=8 and no BCLK. Required:
  - s_ready low after the 8th push;
  - fifo_level=8;
  - 9th pair not accepted until the first pop.
- Assert rst mid left slot. Required:
  - dacdat=0 next cycle;
  - fifo_level=0;
  - no output until the next left start, then correct new data.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared encodings for the stereo DAC serializer: data formats and serializer states.
package audio_pkg;

    localparam logic [1:0] MODE_LJ  = 2'b00;
    localparam logic [1:0] MODE_I2S = 2'b01;
    localparam logic [1:0] MODE_RJ  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } tx_state_e;

    // The reserved encoding 2'b11 behaves as left-justified.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_LJ : m;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO of stereo frames with a registered ready and level.
module sample_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             ready,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push & ready_q;
        // Emptiness is judged on the stored level only, so a same-cycle push never feeds a pop.
        do_pop   = pop & (level_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
        ready_d  = (level_d != LW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (level_q == '0);
    assign ready   = ready_q;
    assign level   = level_q;

endmodule

// File: rtl/audio_dac_tx.sv
// Stereo DACDAT serializer (LJ / I2S / RJ) driven by codec-mastered BCLK and DACLRC.
//   state | meaning
//   IDLE  | waiting for the first left half-frame start, dacdat held low
//   LEFT  | shifting the left holding register
//   RIGHT | shifting the right holding register
module audio_dac_tx
    import audio_pkg::*;
#(
    parameter int  SAMPLE_W   = 16,
    parameter int  SLOT_W     = 32,
    parameter int  FIFO_DEPTH = 8,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk50M,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    input  logic                bclk,
    input  logic                daclrc,
    output logic                dacdat,
    output logic                underrun,
    output logic [15:0]         underrun_cnt,
    output logic [LW-1:0]       fifo_level
);

    logic                  bclk_s1_q, bclk_s2_q, bclk_prev_q;
    logic                  lrc_s1_q, lrc_s2_q;
    logic                  lrc_prev_q, lrc_prev_d;
    logic                  lrc_seen_q, lrc_seen_d;
    tx_state_e             state_q, state_d;
    logic [5:0]            k_q, k_d;
    logic [1:0]            mode_q, mode_d, mode_live;
    logic [SAMPLE_W-1:0]   left_q, left_d, right_q, right_d;
    logic                  dacdat_q, dacdat_d;
    logic [15:0]           ur_cnt_q, ur_cnt_d;
    logic                  fall, lrc_left, half_start, frame_start;
    logic                  fifo_empty;
    logic [2*SAMPLE_W-1:0] fifo_rd_data;
    logic [SAMPLE_W-1:0]   word, shifted;
    logic                  bit_ok;
    int                    kk, sh;

    sample_fifo #(
        .WIDTH (2 * SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk50M),
        .rst     (rst),
        .push    (s_valid),
        .wr_data ({s_left, s_right}),
        .pop     (frame_start),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .ready   (s_ready),
        .level   (fifo_level)
    );

    always_ff @(posedge clk50M) begin
        if (rst) begin
            bclk_s1_q   <= 1'b0;
            bclk_s2_q   <= 1'b0;
            bclk_prev_q <= 1'b0;
            lrc_s1_q    <= 1'b0;
            lrc_s2_q    <= 1'b0;
        end else begin
            bclk_s1_q   <= bclk;
            bclk_s2_q   <= bclk_s1_q;
            bclk_prev_q <= bclk_s2_q;
            lrc_s1_q    <= daclrc;
            lrc_s2_q    <= lrc_s1_q;
        end
    end

    always_comb begin
        fall        = bclk_prev_q & ~bclk_s2_q;
        mode_live   = norm_mode(mode);
        lrc_left    = (mode_live == MODE_I2S) ? ~lrc_s2_q : lrc_s2_q;
        // The first edge after reset only records the LRC level; it cannot start a half-frame.
        half_start  = fall & lrc_seen_q & (lrc_s2_q != lrc_prev_q);
        frame_start = half_start & lrc_left & ~rst;
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        mode_d     = mode_q;
        left_d     = left_q;
        right_d    = right_q;
        dacdat_d   = dacdat_q;
        lrc_prev_d = lrc_prev_q;
        lrc_seen_d = lrc_seen_q;
        word       = '0;
        shifted    = '0;
        bit_ok     = 1'b0;
        kk         = 0;
        sh         = 0;
        if (fall) begin
            lrc_prev_d = lrc_s2_q;
            lrc_seen_d = 1'b1;
            if (half_start) begin
                k_d = '0;
            end else if (k_q != 6'd63) begin
                k_d = k_q + 6'd1;
            end
            case (state_q)
                IDLE:    if (frame_start) state_d = LEFT;
                LEFT:    if (half_start)  state_d = RIGHT;
                RIGHT:   if (half_start)  state_d = LEFT;
                default: state_d = IDLE;
            endcase
            if (frame_start) begin
                mode_d  = mode_live;
                left_d  = fifo_empty ? '0 : fifo_rd_data[2*SAMPLE_W-1:SAMPLE_W];
                right_d = fifo_empty ? '0 : fifo_rd_data[SAMPLE_W-1:0];
            end
            // Bit selection uses the post-edge values so dacdat lands one cycle after detection.
            word = (state_d == RIGHT) ? right_d : left_d;
            kk   = int'(k_d);
            case (mode_d)
                MODE_I2S: begin
                    bit_ok = (kk >= 1) && (kk <= SAMPLE_W);
                    if (bit_ok) sh = SAMPLE_W - kk;
                end
                MODE_RJ: begin
                    bit_ok = (kk >= SLOT_W - SAMPLE_W) && (kk < SLOT_W);
                    if (bit_ok) sh = SLOT_W - 1 - kk;
                end
                default: begin
                    bit_ok = (kk < SAMPLE_W);
                    if (bit_ok) sh = SAMPLE_W - 1 - kk;
                end
            endcase
            shifted  = word >> sh;
            dacdat_d = (state_d != IDLE) & bit_ok & shifted[0];
        end
        underrun = frame_start & fifo_empty;
        ur_cnt_d = ur_cnt_q + 16'((underrun && (ur_cnt_q != 16'hFFFF)) ? 1 : 0);
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            mode_q     <= MODE_LJ;
            left_q     <= '0;
            right_q    <= '0;
            dacdat_q   <= 1'b0;
            lrc_prev_q <= 1'b0;
            lrc_seen_q <= 1'b0;
            ur_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            mode_q     <= mode_d;
            left_q     <= left_d;
            right_q    <= right_d;
            dacdat_q   <= dacdat_d;
            lrc_prev_q <= lrc_prev_d;
            lrc_seen_q <= lrc_seen_d;
            ur_cnt_q   <= ur_cnt_d;
        end
    end

    assign dacdat       = dacdat_q;
    assign underrun_cnt = ur_cnt_q;

endmodule
